// File: rtl/password_check_pkg.sv
// Shared definitions for the ID-check and password-check stages: FSM encoding,
// ROM timing, attempt limit, guest account index and digit-buffer geometry.
package password_check_pkg;

  typedef enum logic [3:0] {
    S_INITIAL     = 4'd0,
    S_WAIT_ID     = 4'd1,
    S_DIGIT_ONE   = 4'd2,
    S_DIGIT_TWO   = 4'd3,
    S_DIGIT_THREE = 4'd4,
    S_DIGIT_FOUR  = 4'd5,
    S_FETCHROM    = 4'd6,
    S_ROMCYC1     = 4'd7,
    S_ROMCYC2     = 4'd8,
    S_ROMCATCH    = 4'd9,
    S_COMPARE     = 4'd10,
    S_AUTH        = 4'd11,
    S_LOCKOUT     = 4'd12
  } pw_state_e;

  localparam int          ROM_WAIT_CYCLES = 3;
  localparam int          MAX_TRIES_DEF   = 3;
  localparam logic [2:0]  GUEST_ID        = 3'd7;
  localparam int          NUM_DIGITS      = 4;
  localparam int          DIGIT_W         = 4;

  // Digit slot written by each DIGIT state; slot 0 is the most significant digit.
  function automatic logic [1:0] digit_pos(input pw_state_e s);
    case (s)
      S_DIGIT_TWO:   return 2'd1;
      S_DIGIT_THREE: return 2'd2;
      S_DIGIT_FOUR:  return 2'd3;
      default:       return 2'd0;
    endcase
  endfunction

  // States in which an entry is in flight and may be aborted.
  function automatic logic is_entry(input pw_state_e s);
    return (s >= S_DIGIT_ONE) && (s <= S_COMPARE);
  endfunction

endpackage

// File: rtl/password_check_digit_buffer.sv
// Entered-password register: four BCD slots, loaded one at a time by position,
// cleared as a whole.
module pw_digit_buffer
  import password_check_pkg::*;
(
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  clr_i,
  input  logic                                  load_i,
  input  logic [1:0]                            pos_i,
  input  logic [DIGIT_W-1:0]                    digit_i,
  output logic [NUM_DIGITS-1:0][DIGIT_W-1:0]    pw_o
);

  localparam logic [1:0] LAST = 2'(NUM_DIGITS - 1);

  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] dig_q;

  // Position 0 lands in the top nibble so the word matches the ROM layout.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      dig_q <= '0;
    end else if (load_i) begin
      dig_q[LAST - pos_i] <= digit_i;
    end
  end

  assign pw_o = dig_q;

endmodule

// File: rtl/password_check.sv
// Password stage: collects four keypad digits for the matched player, fetches
// the stored password from ROM, compares, and tracks failures up to lockout.
module password_check
  import password_check_pkg::*;
#(
  parameter int unsigned MAX_TRIES = MAX_TRIES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  UserDigit,
  input  logic        UserLoad,
  input  logic        matchedID,
  input  logic [2:0]  PlayerID_internal,
  input  logic        isGuest_from_IDCheck,
  input  logic        logout,
  output logic [4:0]  addr_pw,
  input  logic [15:0] data_rom_PW,
  output logic        authenticated,
  output logic        pw_fail,
  output logic        locked,
  output logic [2:0]  tries
);

  localparam logic [2:0] MAX_T = 3'(MAX_TRIES);

  pw_state_e   state_q, state_d;
  logic [4:0]  addr_q, addr_d;
  logic        auth_q, auth_d;
  logic        fail_q, fail_d;
  logic        lock_q, lock_d;
  logic [2:0]  tries_q, tries_d;
  logic [15:0] rom_q, rom_d;
  logic        buf_clr, buf_load;
  logic [15:0] entered;

  pw_digit_buffer u_buf (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (buf_clr),
    .load_i  (buf_load),
    .pos_i   (digit_pos(state_q)),
    .digit_i (UserDigit),
    .pw_o    (entered)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INITIAL;
      addr_q  <= '0;
      auth_q  <= 1'b0;
      fail_q  <= 1'b0;
      lock_q  <= 1'b0;
      tries_q <= '0;
      rom_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      auth_q  <= auth_d;
      fail_q  <= fail_d;
      lock_q  <= lock_d;
      tries_q <= tries_d;
      rom_q   <= rom_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    auth_d   = auth_q;
    fail_d   = 1'b0;
    lock_d   = lock_q;
    tries_d  = tries_q;
    rom_d    = rom_q;
    buf_clr  = 1'b0;
    buf_load = 1'b0;

    case (state_q)
      S_INITIAL: state_d = S_WAIT_ID;
      S_WAIT_ID: begin
        if (matchedID) begin
          if (isGuest_from_IDCheck) begin
            auth_d  = 1'b1;
            state_d = S_AUTH;
          end else begin
            addr_d  = {2'b00, PlayerID_internal};
            state_d = S_DIGIT_ONE;
          end
        end
      end
      // DIGIT_FOUR + 1 is FETCHROM by construction of the encoding.
      S_DIGIT_ONE, S_DIGIT_TWO, S_DIGIT_THREE, S_DIGIT_FOUR: begin
        if (UserLoad) begin
          buf_load = 1'b1;
          state_d  = pw_state_e'(state_q + 4'd1);
        end
      end
      S_FETCHROM: state_d = S_ROMCYC1;
      S_ROMCYC1:  state_d = S_ROMCYC2;
      S_ROMCYC2:  state_d = S_ROMCATCH;
      S_ROMCATCH: begin
        rom_d   = data_rom_PW;
        state_d = S_COMPARE;
      end
      S_COMPARE: begin
        if (entered == rom_q) begin
          auth_d  = 1'b1;
          state_d = S_AUTH;
        end else begin
          tries_d = (tries_q < MAX_T) ? tries_q + 3'd1 : tries_q;
          if (tries_d == MAX_T) begin
            lock_d  = 1'b1;
            state_d = S_LOCKOUT;
          end else begin
            fail_d  = 1'b1;
            buf_clr = 1'b1;
            state_d = S_DIGIT_ONE;
          end
        end
      end
      S_AUTH, S_LOCKOUT: if (logout) state_d = S_INITIAL;
      default: state_d = S_INITIAL;
    endcase

    if (is_entry(state_q) && (logout || !matchedID)) state_d = S_INITIAL;

    // Every path into INITIAL leaves all outputs and internal registers cleared.
    if (state_d == S_INITIAL) begin
      addr_d   = '0;
      auth_d   = 1'b0;
      fail_d   = 1'b0;
      lock_d   = 1'b0;
      tries_d  = '0;
      rom_d    = '0;
      buf_clr  = 1'b1;
      buf_load = 1'b0;
    end
  end

  assign addr_pw       = addr_q;
  assign authenticated = auth_q;
  assign pw_fail       = fail_q;
  assign locked        = lock_q;
  assign tries         = tries_q;

endmodule

// File: doc/password_check.md
PASSWORD_CHECK -- requirements
Module: password_check

Interface
REQ-001 Parameter: MAX_TRIES, 3, wrong-password attempts allowed before lockout (range 1..7).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 UserDigit  input  4  digit value from keypad path; valid when UserLoad=1.
REQ-005 UserLoad  input  1  one-cycle digit strobe.
REQ-006 matchedID  input  1  level from ID-check stage; 1 = valid player ID accepted.
REQ-007 PlayerID_internal  input  3  internal player index from ID-check stage; valid while matchedID=1.
REQ-008 isGuest_from_IDCheck  input  1  level; 1 = matched ID is the guest account.
REQ-009 logout  input  1  level/pulse; ends session or aborts entry.
REQ-010 addr_pw  output  5  password ROM address.
REQ-011 data_rom_PW  input  16  password ROM data, 4 BCD digits, MSB digit first; valid 3 cycles after addr_pw stable.
REQ-012 authenticated  output  1  level; 1 = session open.
REQ-013 pw_fail  output  1  one-cycle pulse per rejected password.
REQ-014 locked  output  1  level; 1 = MAX_TRIES failures reached.
REQ-015 tries  output  3  count of failed attempts in current session.

Function
REQ-016 States: INITIAL, WAIT_ID, DIGIT_ONE..DIGIT_FOUR, FETCHROM, ROMCYC1, ROMCYC2, ROMCATCH, COMPARE, AUTH, LOCKOUT.
REQ-017 INITIAL: clear all outputs, entered-password register and captured-ROM register; next WAIT_ID.
REQ-018 WAIT_ID: ignore UserLoad; on matchedID=1 with isGuest=1 -> AUTH with authenticated=1 (no password); with isGuest=0 -> addr_pw={2'b00,PlayerID_internal}, -> DIGIT_ONE.
REQ-019 DIGIT_ONE..FOUR: on UserLoad=1 store UserDigit into bits [15:12],[11:8],[7:4],[3:0] respectively and advance; else hold.
REQ-020 DIGIT_FOUR load -> FETCHROM -> ROMCYC1 -> ROMCYC2 -> ROMCATCH (latch data_rom_PW) -> COMPARE; one cycle each, addr_pw held constant throughout.
REQ-021 COMPARE, equal: authenticated=1, -> AUTH; authenticated rises 5 clocks after the edge that captured digit four.
REQ-022 COMPARE, unequal: tries+1; if new tries==MAX_TRIES -> LOCKOUT with locked=1, no pw_fail; else pw_fail=1 for exactly one cycle, -> DIGIT_ONE with entered register cleared.
REQ-023 AUTH: hold authenticated=1; logout=1 -> INITIAL.
REQ-024 LOCKOUT: hold locked=1, ignore UserLoad; logout=1 -> INITIAL.
REQ-025 Abort: in any DIGIT, FETCHROM..COMPARE state, logout=1 or matchedID=0 -> INITIAL next edge; logout has priority over UserLoad and over COMPARE result.
REQ-026 tries saturates at MAX_TRIES; never wraps; cleared only in INITIAL.
REQ-027 UserLoad in FETCHROM..COMPARE is dropped (not buffered).
REQ-028 Unreachable state encodings -> INITIAL with outputs cleared.

Reset
REQ-029 rst=1 at a clock edge: state=INITIAL, addr_pw=0, authenticated=0, pw_fail=0, locked=0, tries=0, internal registers 0; takes priority over every input, including mid-ROM-wait.
REQ-030 No asynchronous reset paths; outputs are registered.

Structure
REQ-031 Shared package holds state encoding, ROM wait count (3), MAX_TRIES default, and guest ID constant used by both ID and password stages.
REQ-032 One sub-module natural: pw_digit_buffer (4x4-bit digit load/clear register with digit-position select); all else in one FSM process.

Verification
REQ-033 ROM[2]=16'h1234; matchedID=1, ID=2, digits 1,2,3,4 -> addr_pw=2, authenticated=1 exactly 5 clocks after 4th load, pw_fail never pulses.
REQ-034 Same setup, digits 1,2,3,5 -> pw_fail one-cycle pulse, tries=1, FSM back in DIGIT_ONE; then 1,2,3,4 -> authenticated=1, tries stays 1.
REQ-035 Three wrong entries (MAX_TRIES=3) -> pw_fail pulses twice, locked=1 after third, tries=3; further correct digits ignored; logout -> all outputs 0.
REQ-036 isGuest=1 with matchedID=1 -> authenticated=1 next clock, addr_pw unchanged 0, no digits consumed.
REQ-037 logout asserted in ROMCYC1 after correct entry -> INITIAL, authenticated stays 0; rst=1 during AUTH -> authenticated=0 next edge.
REQ-038 matchedID drops after two digits -> INITIAL; UserLoad during ROMCYC2 -> no effect on compare result.
